// File: rtl/nios_hex_display_bank.sv
// nios_hex_display_bank
// Avalon-MM slave holding one register bank for a row of seven-segment digits.
// Each digit shows either a raw segment pattern or a hardware-decoded hex
// nibble, and any subset of digits can blink from a built-in prescaler.

module nios_hex_display_bank #(
   parameter int NUM_DIGITS = 6,
   parameter int SEG_WIDTH  = 7,
   parameter int ADDR_W     = 4,
   parameter int BLINK_DIV  = 25000000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [ADDR_W-1:0]               address,
   input  logic                            chipselect,
   input  logic                            write_n,
   input  logic [31:0]                     writedata,
   output logic [31:0]                     readdata,
   output logic [NUM_DIGITS*SEG_WIDTH-1:0] out_port,
   output logic                            blink_phase
);

   localparam int OUT_W = NUM_DIGITS * SEG_WIDTH;
   localparam int CNT_W = $clog2(BLINK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
   localparam logic [OUT_W-1:0] ALL_OFF  = {OUT_W{(ACTIVE_LOW != 0)}};

   logic                  write_en;
   logic                  ctrl_write;
   logic                  decode_en;
   logic                  blank_all;
   logic                  blink_en;
   logic [NUM_DIGITS-1:0] blink_mask;
   logic [SEG_WIDTH-1:0]  digit [NUM_DIGITS];
   logic [CNT_W-1:0]      blink_cnt;
   logic [OUT_W-1:0]      out_next;
   logic [SEG_WIDTH-1:0]  raw;
   logic [SEG_WIDTH-1:0]  seg;
   logic                  visible;

   assign write_en   = chipselect && !write_n;
   assign ctrl_write = write_en && (address == ADDR_W'(0));

   // Hex nibble to gfedcba pattern, lit = 1.
   function automatic logic [6:0] hex7(input logic [3:0] nibble);
      logic [6:0] pattern;
      case (nibble)
         4'h0: pattern = 7'h3F;
         4'h1: pattern = 7'h06;
         4'h2: pattern = 7'h5B;
         4'h3: pattern = 7'h4F;
         4'h4: pattern = 7'h66;
         4'h5: pattern = 7'h6D;
         4'h6: pattern = 7'h7D;
         4'h7: pattern = 7'h07;
         4'h8: pattern = 7'h7F;
         4'h9: pattern = 7'h6F;
         4'hA: pattern = 7'h77;
         4'hB: pattern = 7'h7C;
         4'hC: pattern = 7'h39;
         4'hD: pattern = 7'h5E;
         4'hE: pattern = 7'h79;
         default: pattern = 7'h71;
      endcase
      return pattern;
   endfunction

   // Control and blink-mask registers, written whole-word from the bus.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         decode_en  <= 1'b0;
         blank_all  <= 1'b0;
         blink_en   <= 1'b0;
         blink_mask <= '0;
      end else begin
         if (ctrl_write) begin
            decode_en <= writedata[0];
            blank_all <= writedata[1];
            blink_en  <= writedata[2];
         end
         if (write_en && (address == ADDR_W'(1))) begin
            blink_mask <= writedata[NUM_DIGITS-1:0];
         end
      end
   end

   // One segment/nibble register per digit at word address 4+i.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digit[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (write_en && (address == ADDR_W'(4 + i))) begin
               digit[i] <= writedata[SEG_WIDTH-1:0];
            end
         end
      end
   end

   // Blink prescaler: a CTRL write that clears or newly sets blink_en
   // restarts from counter 0 / phase 1, and beats a wrap on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (ctrl_write && (!writedata[2] || !blink_en)) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (blink_en) begin
         if (blink_cnt == CNT_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
         end
      end else begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end
   end

   // Build every digit's pattern from the current register and phase state;
   // the decoder only replaces a..g so a dp bit passes through untouched.
   always_comb begin
      out_next = '0;
      raw      = '0;
      seg      = '0;
      visible  = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         raw = digit[i];
         if (decode_en) begin
            raw[6:0] = hex7(digit[i][3:0]);
         end
         visible = !blank_all && (blink_phase || !blink_mask[i]);
         seg     = visible ? raw : '0;
         out_next[i*SEG_WIDTH +: SEG_WIDTH] = (ACTIVE_LOW != 0) ? ~seg : seg;
      end
   end

   // Registered display output so the pins change cleanly on a clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_port <= ALL_OFF;
      end else begin
         out_port <= out_next;
      end
   end

   // Zero-wait-state read mux, selected by address alone like the old PIOs.
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_W'(0): readdata[2:0] = {blink_en, blank_all, decode_en};
         ADDR_W'(1): readdata[NUM_DIGITS-1:0] = blink_mask;
         ADDR_W'(2): begin
            readdata[0]     = blink_phase;
            readdata[15:8]  = 8'(NUM_DIGITS);
            readdata[19:16] = 4'(SEG_WIDTH);
         end
         default: begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (address == ADDR_W'(4 + i)) begin
                  readdata[SEG_WIDTH-1:0] = digit[i];
               end
            end
         end
      endcase
   end

endmodule
